// File: rtl/cu_pkg.sv
// cu_pkg: state encodings and widths shared by the control-unit sequencer blocks.
package cu_pkg;
    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;
    localparam int TSTATE_W = 4;
endpackage

// File: rtl/micro_stack.sv
// micro_stack: LIFO of return addresses; push onto a full stack or pop of an empty one is ignored.
module micro_stack #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] din_i,
    output logic [AW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [AW-1:0] mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;
    assign wr_idx  = IW'(cnt_q);
    assign top_idx = IW'(cnt_q - CW'(1));
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign top_o   = mem_q[top_idx];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(negedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= din_i;
    end
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (do_push) cnt_q <= cnt_q + CW'(1);
        else if (do_pop) cnt_q <= cnt_q - CW'(1);
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/exec/halt micro-address sequencer with call/return stack, clocked on the falling edge.
module micro_sequencer
    import cu_pkg::*;
#(
    parameter int AW        = 10,
    parameter int FETCH_LEN = 3,
    parameter int DEPTH     = 4
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [AW-1:0]       OpCodeStart,
    input  logic                Stall,
    input  logic                End,
    input  logic                Jmp,
    input  logic                Cond,
    input  logic                Call,
    input  logic                Ret,
    input  logic [AW-1:0]       Target,
    input  logic                Hlt,
    output logic [AW-1:0]       OpCodeAdd,
    output logic [TSTATE_W-1:0] Tstate,
    output logic                Halted,
    output logic                StkErr
);
    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d, addr_inc, stk_top;
    logic [TSTATE_W-1:0] tst_q, tst_d;
    logic                err_q, err_d;
    logic                push, pop, stk_full, stk_empty, fetch_last;
    assign addr_inc   = addr_q + AW'(1);
    assign fetch_last = tst_q == TSTATE_W'(FETCH_LEN - 1);
    micro_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .clk_i  (Clk),
        .rst_ni (Clr),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (addr_inc),
        .top_o  (stk_top),
        .full_o (stk_full),
        .empty_o(stk_empty)
    );
    // Stall outranks everything, so both active states are gated by it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tst_d   = tst_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!Stall && state_q == ST_FETCH) begin
            addr_d  = fetch_last ? OpCodeStart : addr_inc;
            tst_d   = fetch_last ? '0 : tst_q + TSTATE_W'(1);
            state_d = fetch_last ? ST_EXEC : ST_FETCH;
        end else if (!Stall && state_q == ST_EXEC) begin
            if (Hlt) begin
                state_d = ST_HALT;
            end else if (End) begin
                addr_d  = '0;
                tst_d   = '0;
                state_d = ST_FETCH;
            end else if (Ret) begin
                err_d   = err_q | stk_empty;
                state_d = stk_empty ? ST_HALT : ST_EXEC;
                pop     = !stk_empty;
                addr_d  = stk_empty ? addr_q : stk_top;
            end else if (Call) begin
                err_d   = err_q | stk_full;
                state_d = stk_full ? ST_HALT : ST_EXEC;
                push    = !stk_full;
                addr_d  = stk_full ? addr_q : Target;
            end else begin
                addr_d = Jmp && Cond ? Target : addr_inc;
            end
        end
    end
    always_ff @(negedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_FETCH;
            addr_q  <= '0;
            tst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tst_q   <= tst_d;
            err_q   <= err_d;
        end
    end
    assign OpCodeAdd = addr_q;
    assign Tstate    = tst_q;
    assign Halted    = state_q == ST_HALT;
    assign StkErr    = err_q;
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have a parameter AW, default 10, giving the micro-address width.
REQ-002 The block SHALL have a parameter FETCH_LEN, default 3, giving the number of fetch micro-steps before an opcode dispatch.
REQ-003 The block SHALL have a parameter DEPTH, default 4, giving the number of micro-stack entries (range 1..16).
REQ-004 Port Clk, input, 1 bit: the single clock; all state SHALL update on the falling edge of Clk.
REQ-005 Port Clr, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port OpCodeStart, input, AW bits: the dispatch address from the opcode address ROM.
REQ-007 Port Stall, input, 1 bit: holds all state unchanged.
REQ-008 Port End, input, 1 bit: end of the current instruction; returns the sequencer to fetch.
REQ-009 Port Jmp, input, 1 bit: conditional micro-jump request.
REQ-010 Port Cond, input, 1 bit: the jump condition; a jump is taken only when Jmp=1 and Cond=1.
REQ-011 Port Call, input, 1 bit: micro-subroutine call request.
REQ-012 Port Ret, input, 1 bit: micro-subroutine return request.
REQ-013 Port Target, input, AW bits: the destination address for Jmp and Call.
REQ-014 Port Hlt, input, 1 bit: halt request.
REQ-015 Port OpCodeAdd, output, AW bits: the current micro-address driven to the control ROM.
REQ-016 Port Tstate, output, 4 bits: the fetch step count.
REQ-017 Port Halted, output, 1 bit: high while the sequencer is in HALT.
REQ-018 Port StkErr, output, 1 bit: sticky micro-stack overflow/underflow flag.

Function
REQ-019 The sequencer SHALL have three states: FETCH, EXEC and HALT.
REQ-020 In FETCH, each cycle SHALL increment OpCodeAdd by 1 and increment Tstate by 1.
REQ-021 In FETCH, when Tstate=FETCH_LEN-1, the next edge SHALL load OpCodeAdd<=OpCodeStart, set Tstate<=0 and enter EXEC.
REQ-022 In EXEC, the next-address priority SHALL be, highest first: Stall (hold), Hlt, End, Ret, Call, Jmp with Cond=1, increment.
REQ-023 Hlt in EXEC SHALL enter HALT and hold OpCodeAdd.
REQ-024 End SHALL set OpCodeAdd<=0 and Tstate<=0 and enter FETCH.
REQ-025 Call SHALL push OpCodeAdd+1 onto the micro-stack and load Target.
REQ-026 Ret SHALL pop the micro-stack top into OpCodeAdd.
REQ-027 Jmp with Cond=1 SHALL load Target; Jmp with Cond=0 SHALL increment.
REQ-028 Call when the micro-stack holds DEPTH entries SHALL set StkErr and enter HALT; the stack SHALL be unchanged.
REQ-029 Ret when the micro-stack is empty SHALL set StkErr and enter HALT.
REQ-030 Micro-address arithmetic SHALL be modulo 2^AW: 2^AW-1 increments to 0.
REQ-031 Call, Ret, Jmp and End SHALL be ignored in FETCH; Stall SHALL still hold in FETCH.
REQ-032 HALT SHALL be left only by reset; Halted=1 in HALT.
REQ-033 End in the same cycle as Call or Ret SHALL win, and the stack SHALL be untouched.
REQ-034 End SHALL NOT clear the micro-stack.

Reset
REQ-035 When Clr=0 the block SHALL, asynchronously, set OpCodeAdd=0, Tstate=0, state FETCH, micro-stack empty, Halted=0 and StkErr=0.
REQ-036 Reset asserted mid-instruction or in HALT SHALL take effect immediately.
REQ-037 Fetch SHALL restart on the first falling edge after Clr rises.

Structure
REQ-038 State encodings (FETCH=2'b00, EXEC=2'b01, HALT=2'b10) SHALL live in a shared package, cu_pkg.
REQ-039 The micro-stack SHALL be one sub-module, micro_stack, with DEPTH entries of AW bits, push/pop inputs and full/empty outputs.

Verification
REQ-040 Reset followed by 3 edges with OpCodeStart=10'h045 SHALL give OpCodeAdd 0,1,2 then 10'h045, Tstate 0,1,2,0, with state EXEC.
REQ-041 In EXEC at 10'h045, Call with Target=10'h200, three increments, then Ret SHALL give OpCodeAdd 10'h200, 10'h201, 10'h202, 10'h203, then 10'h046.
REQ-042 Jmp with Target=10'h300 SHALL give 10'h300 when Cond=1 and OpCodeAdd+1 when Cond=0; Jmp with Cond=1 together with Stall SHALL leave the address unchanged.
REQ-043 Five Calls with DEPTH=4 SHALL set StkErr=1 and Halted=1 on the fifth; a Ret on an empty stack from a fresh reset SHALL do the same.
REQ-044 At OpCodeAdd=10'h3FF, an increment SHALL give 10'h000; End SHALL give OpCodeAdd=0 and FETCH with the stack depth preserved.
REQ-045 Clr pulsed low between clock edges while in HALT SHALL clear Halted, StkErr and OpCodeAdd at once, without waiting for a clock edge.
